// File: rtl/servant_arb_pkg.sv
// Shared encodings for the servant RAM arbiter.
// State, grant and timeout defaults.
package servant_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_M0   = 2'b01;
  localparam logic [1:0] GNT_M1   = 2'b10;

  localparam int TIMEOUT_DEF = 16;

endpackage

// File: rtl/servant_arb_rr.sv
// Two-input round-robin picker.
// last=1 means m1 owned the bus most recently.
module servant_arb_rr
  import servant_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = GNT_NONE;
    unique case (1'b1)
      (req == 2'b11): gnt = last ? GNT_M0 : GNT_M1;
      (req == 2'b01): gnt = GNT_M0;
      (req == 2'b10): gnt = GNT_M1;
      (req == 2'b00): gnt = GNT_NONE;
      default:        gnt = GNT_NONE;
    endcase
  end

endmodule

// File: rtl/servant_ram_arbiter.sv
// Two-master Wishbone arbiter in front of the servant RAM.
// Round-robin, one transaction in flight, watchdog abort.
module servant_ram_arbiter
  import servant_arb_pkg::*;
#(
  parameter int aw      = 8,
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int TW      = $clog2(TIMEOUT + 1)
) (
  input  logic          i_wb_clk,
  input  logic          i_wb_rst_n,
  input  logic [aw-3:0] i_m0_adr,
  input  logic [31:0]   i_m0_dat,
  input  logic [3:0]    i_m0_sel,
  input  logic          i_m0_we,
  input  logic          i_m0_cyc,
  output logic [31:0]   o_m0_rdt,
  output logic          o_m0_ack,
  input  logic [aw-3:0] i_m1_adr,
  input  logic [31:0]   i_m1_dat,
  input  logic [3:0]    i_m1_sel,
  input  logic          i_m1_we,
  input  logic          i_m1_cyc,
  output logic [31:0]   o_m1_rdt,
  output logic          o_m1_ack,
  output logic [aw-3:0] o_s_adr,
  output logic [31:0]   o_s_dat,
  output logic [3:0]    o_s_sel,
  output logic          o_s_we,
  output logic          o_s_cyc,
  input  logic [31:0]   i_s_rdt,
  input  logic          i_s_ack,
  output logic [1:0]    o_grant,
  output logic          o_timeout
);

  state_t        state, state_nx;
  logic [1:0]    gnt, gnt_nx;
  logic          last, last_nx;
  logic [TW-1:0] cnt, cnt_nx;
  logic [1:0]    pick;
  logic          act, sel0, sel1;
  logic          gcyc, tmo;

  servant_arb_rr u_rr (
    .req  ({i_m1_cyc, i_m0_cyc}),
    .last (last),
    .gnt  (pick)
  );

  assign act  = (state == ACTIVE);
  assign sel0 = act & (gnt == GNT_M0);
  assign sel1 = act & (gnt == GNT_M1);
  assign gcyc = (sel0 & i_m0_cyc) | (sel1 & i_m1_cyc);
  assign tmo  = gcyc & ~i_s_ack
              & (cnt == TW'(TIMEOUT - 1));

  always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
    if (!i_wb_rst_n) begin
      state <= IDLE;
      gnt   <= GNT_NONE;
      last  <= 1'b1;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      gnt   <= gnt_nx;
      last  <= last_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    gnt_nx   = gnt;
    last_nx  = last;
    cnt_nx   = cnt;
    unique case (state)
      IDLE: begin
        if (pick != GNT_NONE) begin
          state_nx = ACTIVE;
          gnt_nx   = pick;
          last_nx  = (pick == GNT_M1);
          cnt_nx   = '0;
        end
      end
      ACTIVE: begin
        cnt_nx = cnt + TW'(1);
        // ack, abort and timeout all close the transaction
        if (!gcyc || i_s_ack || tmo) begin
          state_nx = IDLE;
          gnt_nx   = GNT_NONE;
        end
      end
      default: begin
        state_nx = IDLE;
        gnt_nx   = GNT_NONE;
      end
    endcase
  end

  always_comb begin
    o_s_adr = '0;
    o_s_dat = '0;
    o_s_sel = '0;
    o_s_we  = 1'b0;
    unique case (1'b1)
      sel0: begin
        o_s_adr = i_m0_adr;
        o_s_dat = i_m0_dat;
        o_s_sel = i_m0_sel;
        o_s_we  = i_m0_we;
      end
      sel1: begin
        o_s_adr = i_m1_adr;
        o_s_dat = i_m1_dat;
        o_s_sel = i_m1_sel;
        o_s_we  = i_m1_we;
      end
      default: ;
    endcase
  end

  assign o_s_cyc   = gcyc;
  assign o_grant   = gnt;
  assign o_timeout = tmo;

  assign o_m0_ack = sel0 & i_m0_cyc & (i_s_ack | tmo);
  assign o_m1_ack = sel1 & i_m1_cyc & (i_s_ack | tmo);
  assign o_m0_rdt = (sel0 & ~tmo) ? i_s_rdt : 32'h0;
  assign o_m1_rdt = (sel1 & ~tmo) ? i_s_rdt : 32'h0;

endmodule

// File: tb/tb_servant_ram_arbiter.sv
// Directed bench for servant_ram_arbiter.
// Vector table plus hand-written multi-cycle sequences.
module tb_servant_ram_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [5:0]  m0_adr, m1_adr;
  logic [31:0] m0_dat, m1_dat;
  logic [3:0]  m0_sel, m1_sel;
  logic        m0_we, m1_we, m0_cyc, m1_cyc;
  logic [31:0] m0_rdt, m1_rdt;
  logic        m0_ack, m1_ack;
  logic [5:0]  s_adr;
  logic [31:0] s_dat;
  logic [3:0]  s_sel;
  logic        s_we, s_cyc;
  logic [31:0] s_rdt;
  logic        s_ack;
  logic [1:0]  grant;
  logic        tmo;

  logic        use_ram = 1'b0;
  logic        drv_ack = 1'b0;
  logic [31:0] drv_rdt = 32'h0;
  logic        ram_ack = 1'b0;
  logic [31:0] ram_rdt = 32'h0;
  logic        noack = 1'b0;
  logic        pl_en = 1'b0;
  logic [5:0]  pl_adr = 6'h0;
  logic [31:0] pl_dat = 32'h0;
  logic [31:0] mem [64];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  assign s_ack = use_ram ? ram_ack : drv_ack;
  assign s_rdt = use_ram ? ram_rdt : drv_rdt;

  servant_ram_arbiter dut (
    .i_wb_clk   (clk),
    .i_wb_rst_n (rst_n),
    .i_m0_adr   (m0_adr),
    .i_m0_dat   (m0_dat),
    .i_m0_sel   (m0_sel),
    .i_m0_we    (m0_we),
    .i_m0_cyc   (m0_cyc),
    .o_m0_rdt   (m0_rdt),
    .o_m0_ack   (m0_ack),
    .i_m1_adr   (m1_adr),
    .i_m1_dat   (m1_dat),
    .i_m1_sel   (m1_sel),
    .i_m1_we    (m1_we),
    .i_m1_cyc   (m1_cyc),
    .o_m1_rdt   (m1_rdt),
    .o_m1_ack   (m1_ack),
    .o_s_adr    (s_adr),
    .o_s_dat    (s_dat),
    .o_s_sel    (s_sel),
    .o_s_we     (s_we),
    .o_s_cyc    (s_cyc),
    .i_s_rdt    (s_rdt),
    .i_s_ack    (s_ack),
    .o_grant    (grant),
    .o_timeout  (tmo)
  );

  // RAM slave: one-cycle ack generator, byte-enabled writes
  always @(posedge clk) begin
    if (pl_en) mem[pl_adr] <= pl_dat;
    ram_ack <= s_cyc & ~ram_ack & ~noack;
    if (s_cyc) ram_rdt <= mem[s_adr];
    if (s_cyc & s_we & ~ram_ack) begin
      for (int b = 0; b < 4; b++)
        if (s_sel[b]) mem[s_adr][8*b +: 8] <= s_dat[8*b +: 8];
    end
  end

  task automatic check(input string nm,
                       input logic [127:0] got,
                       input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    m0_cyc = 0; m1_cyc = 0;
    m0_adr = 0; m1_adr = 0;
    m0_we = 0;  m1_we = 0;
    m0_sel = 4'hf; m1_sel = 4'hf;
    m0_dat = 0; m1_dat = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outs",
          {grant, s_cyc, m0_ack, m1_ack, tmo, m0_rdt, m1_rdt},
          '0);
    rst_n = 1;
  endtask

  task automatic preload(input logic [5:0] a, input logic [31:0] d);
    pl_adr = a; pl_dat = d; pl_en = 1;
    @(posedge clk);
    #1;
    pl_en = 0;
  endtask

  // single master transaction; returns rdt, o_s_cyc latency, ack latency
  task automatic run_xact(input int m, input logic [5:0] a,
                          input logic we, input logic [3:0] sel,
                          input logic [31:0] d,
                          output logic [31:0] rdt,
                          output int cyc_lat, output int ack_lat);
    bit done = 0;
    rdt = 0; cyc_lat = -1; ack_lat = -1;
    if (m == 0) begin
      m0_adr = a; m0_we = we; m0_sel = sel; m0_dat = d; m0_cyc = 1;
    end else begin
      m1_adr = a; m1_we = we; m1_sel = sel; m1_dat = d; m1_cyc = 1;
    end
    for (int t = 1; t <= 40 && !done; t++) begin
      step();
      if (s_cyc && cyc_lat < 0) cyc_lat = t;
      if ((m == 0 && m0_ack) || (m == 1 && m1_ack)) begin
        rdt = (m == 0) ? m0_rdt : m1_rdt;
        ack_lat = t;
        done = 1;
      end
    end
    if (!done) begin
      n_cmp++; n_bad++;
      $display("FAIL xact_timeout: no ack for master %0d", m);
    end
    step();
    m0_cyc = 0; m1_cyc = 0;
  endtask

  typedef struct {
    logic        m0c, m1c;
    logic [5:0]  m0a, m1a;
    logic        sack;
    logic [31:0] srdt;
    logic [1:0]  g;
    logic        scyc;
    logic [5:0]  sadr;
    logic        swe;
    logic        a0, a1;
    logic [31:0] r0, r1;
  } vec_t;

  vec_t vt [11];

  initial begin
    logic [31:0] rd;
    int cl, al, k;
    bit seen;
    logic [1:0] eg;
    logic [127:0] snap;

    // m0c m1c m0a m1a sack srdt | g scyc sadr swe a0 a1 r0 r1
    vt[0]  = '{0,0,6'h05,6'h10,0,32'h0,        2'b00,0,6'h00,0,0,0,32'h0,32'h0};
    vt[1]  = '{1,0,6'h05,6'h10,0,32'h0,        2'b00,0,6'h00,0,0,0,32'h0,32'h0};
    vt[2]  = '{1,0,6'h05,6'h10,0,32'h0,        2'b01,1,6'h05,0,0,0,32'h0,32'h0};
    vt[3]  = '{1,0,6'h05,6'h10,1,32'h12345678, 2'b01,1,6'h05,0,1,0,32'h12345678,32'h0};
    vt[4]  = '{0,1,6'h05,6'h10,1,32'hdeadbeef, 2'b00,0,6'h00,0,0,0,32'h0,32'h0};
    vt[5]  = '{1,1,6'h07,6'h10,0,32'h0,        2'b10,1,6'h10,1,0,0,32'h0,32'h0};
    vt[6]  = '{1,1,6'h07,6'h10,1,32'hdeadbeef, 2'b10,1,6'h10,1,0,1,32'h0,32'hdeadbeef};
    vt[7]  = '{1,0,6'h07,6'h10,0,32'h0,        2'b00,0,6'h00,0,0,0,32'h0,32'h0};
    vt[8]  = '{1,0,6'h07,6'h10,0,32'h0,        2'b01,1,6'h07,0,0,0,32'h0,32'h0};
    vt[9]  = '{0,0,6'h07,6'h10,0,32'h0,        2'b01,0,6'h07,0,0,0,32'h0,32'h0};
    vt[10] = '{0,0,6'h07,6'h10,0,32'h0,        2'b00,0,6'h00,0,0,0,32'h0,32'h0};

    do_reset();

    m1_we = 1; m1_sel = 4'b0010; m1_dat = 32'haabbccdd;
    for (int i = 0; i < 11; i++) begin
      step();
      m0_cyc = vt[i].m0c; m1_cyc = vt[i].m1c;
      m0_adr = vt[i].m0a; m1_adr = vt[i].m1a;
      drv_ack = vt[i].sack; drv_rdt = vt[i].srdt;
      #1;
      check($sformatf("vec%0d", i),
            {grant, s_cyc, s_adr, s_we, m0_ack, m1_ack, m0_rdt, m1_rdt},
            {vt[i].g, vt[i].scyc, vt[i].sadr, vt[i].swe,
             vt[i].a0, vt[i].a1, vt[i].r0, vt[i].r1});
      if (vt[i].g == 2'b10)
        check($sformatf("vec%0d_sdat", i), {s_dat, s_sel},
              {32'haabbccdd, 4'b0010});
    end
    drv_ack = 0;

    use_ram = 1;
    for (int i = 0; i < 64; i++) preload(6'(i), 32'h0);
    preload(6'h05, 32'h12345678);
    preload(6'h01, 32'h11111111);
    preload(6'h02, 32'h22222222);
    preload(6'h03, 32'hcafef00d);
    do_reset();

    run_xact(0, 6'h05, 0, 4'hf, 0, rd, cl, al);
    check("single_rdt", rd, 32'h12345678);
    check("single_cyc_lat", cl, 1);
    check("single_ack_lat", al, 2);

    do_reset();
    m0_adr = 6'h01; m1_adr = 6'h02;
    m0_cyc = 1; m1_cyc = 1;
    step();
    check("both_t1", {grant, s_cyc}, {2'b01, 1'b1});
    step();
    check("both_t2", {m0_ack, m1_ack, m0_rdt}, {1'b1, 1'b0, 32'h11111111});
    step();
    m0_cyc = 0;
    check("both_t3_gap", {grant, s_cyc, m1_ack}, {2'b00, 1'b0, 1'b0});
    step();
    check("both_t4", {grant, s_cyc, s_adr}, {2'b10, 1'b1, 6'h02});
    step();
    check("both_t5", {m1_ack, m1_rdt, m0_ack}, {1'b1, 32'h22222222, 1'b0});
    step();
    m1_cyc = 0;

    do_reset();
    m0_adr = 6'h01; m1_adr = 6'h02;
    m0_cyc = 1; m1_cyc = 1;
    for (int i = 0; i < 8; i++) begin
      seen = 0;
      for (int t = 0; t < 10 && !seen; t++) begin
        step();
        if (grant != 2'b00) seen = 1;
      end
      eg = (i % 2 == 0) ? 2'b01 : 2'b10;
      check($sformatf("fair%0d", i), grant, eg);
      seen = 0;
      for (int t = 0; t < 10 && !seen; t++) begin
        if (m0_ack || m1_ack) seen = 1;
        else step();
      end
      if (!seen) check($sformatf("fair%0d_ack", i), 1'b0, 1'b1);
    end
    step();
    m0_cyc = 0; m1_cyc = 0;
    step();

    run_xact(1, 6'h10, 1, 4'b0010, 32'haabbccdd, rd, cl, al);
    run_xact(0, 6'h10, 0, 4'hf, 0, rd, cl, al);
    check("byte_write_rdt", rd, 32'h0000cc00);

    noack = 1;
    m0_adr = 6'h03; m0_we = 0; m0_cyc = 1;
    k = 0; seen = 0; snap = '0;
    for (int t = 0; t < 40 && !seen; t++) begin
      step();
      if (grant != 2'b00) k++;
      if (tmo) begin
        seen = 1;
        snap = {m0_ack, m0_rdt, s_rdt != 32'h0};
      end
    end
    check("tmo_cycles", k, 16);
    check("tmo_ack_rdt", snap, {1'b1, 32'h0, 1'b1});
    step();
    m0_cyc = 0;
    check("tmo_after", {grant, tmo, s_cyc}, {2'b00, 1'b0, 1'b0});
    noack = 0;
    step();

    run_xact(0, 6'h01, 0, 4'hf, 0, rd, cl, al);
    m1_adr = 6'h04; m1_we = 0; m1_cyc = 1;
    step();
    check("rst_pre", {grant, s_cyc}, {2'b10, 1'b1});
    rst_n = 0;
    #1;
    check("rst_async", {grant, s_cyc, m1_ack}, {2'b00, 1'b0, 1'b0});
    for (int t = 0; t < 2; t++) begin
      step();
      check($sformatf("rst_hold%0d", t), {m1_ack, s_cyc}, 2'b00);
    end
    rst_n = 1;
    m0_adr = 6'h01; m0_cyc = 1;
    step();
    check("rst_restart", grant, 2'b01);
    m0_cyc = 0; m1_cyc = 0;
    repeat (3) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/servant_ram_arbiter.md
Name: servant_ram_arbiter

Overview:
- Two-master Wishbone-classic arbiter sharing one servant RAM slave port.
- m0 is the SERV CPU bus; m1 is a secondary master (UART boot loader / debug writer).
- Round-robin grant, one transaction in flight, per-transaction ack routing, and a watchdog timeout that force-terminates a hung slave access.

Parameters:
- aw, 8, byte-address width of the RAM (matches RAM depth 256); word address bits [aw-1:2].
- TIMEOUT, 16, cycles in ACTIVE without slave ack before forced termination; must be >=2.
- TW, $clog2(TIMEOUT+1), timeout counter width.

Ports:
- i_wb_clk  in  1  clock
- i_wb_rst_n  in  1  asynchronous active-low reset
- i_m0_adr / i_m1_adr  in  aw-2 each  master word address
- i_m0_dat / i_m1_dat  in  32 each  master write data
- i_m0_sel / i_m1_sel  in  4 each  byte enables
- i_m0_we / i_m1_we  in  1 each  write enable
- i_m0_cyc / i_m1_cyc  in  1 each  request, held until ack
- o_m0_rdt / o_m1_rdt  out  32 each  read data
- o_m0_ack / o_m1_ack  out  1 each  transaction done
- o_s_adr  out  aw-2  to RAM
- o_s_dat  out  32  to RAM
- o_s_sel  out  4  to RAM
- o_s_we  out  1  to RAM
- o_s_cyc  out  1  to RAM
- i_s_rdt  in  32  from RAM
- i_s_ack  in  1  from RAM (asserted one cycle after cyc, self-clearing)
- o_grant  out  2  one-hot current owner; 00 when idle
- o_timeout  out  1  single-cycle pulse on forced termination

Behaviour:
- Reset (async, i_wb_rst_n=0): state=IDLE, gnt=none, last=m1 (so m0 wins first tie), cnt=0. All outputs 0.
- States: IDLE, ACTIVE.
- IDLE: o_s_cyc=0; i_s_ack is ignored.
  - Request from only one master -> grant it.
  - Requests from both -> grant the master != last.
  - On the granting edge: latch gnt, set last=gnt, cnt=0, go to ACTIVE.
- ACTIVE: slave request fields are muxed from the granted master (combinational).
  - o_s_cyc = granted i_cyc.
  - cnt increments each cycle.
- Ack routing: o_mX_ack = ACTIVE & gnt==X & i_mX_cyc & i_s_ack. o_mX_rdt = i_s_rdt when gnt==X, else 0.
- Exit ACTIVE to IDLE on any of:
  - routed ack;
  - granted master dropping cyc (abort);
  - cnt==TIMEOUT-1 with no ack. This forces o_mX_ack=1, o_mX_rdt=0 and o_timeout=1 in that same cycle.
- Mandatory IDLE cycle between transactions. Its purpose is to guarantee the RAM's cyc&!ack ack generator is clear; a stray ack during IDLE is discarded.
- Latency: cyc asserted in cycle n -> o_s_cyc in n+1 -> o_mX_ack in n+2. Minimum 3 cycles per transaction.
- The non-granted master sees ack=0 and waits; its request fields never reach the slave.
- Simultaneous new request and ack completion: the new request is arbitrated in the following IDLE cycle.
- Fairness: with both masters continuously requesting, grants alternate strictly.
- Reset asserted mid-ACTIVE: outputs drop immediately (async), no ack is issued, and arbitration restarts from m0 priority.

Decomposition:
- Package servant_arb_pkg:
  - state encoding (IDLE=1'b0, ACTIVE=1'b1);
  - grant encodings (GNT_NONE=2'b00, GNT_M0=2'b01, GNT_M1=2'b10);
  - TIMEOUT default.
- Sub-module servant_arb_rr: combinational 2-input round-robin picker (req[1:0], last -> gnt one-hot). The top holds the FSM, counter, muxes and ack routing.

Test Plan:
- m0 read addr 0x05 alone, RAM word=0x12345678 -> o_s_cyc rises 1 cycle later; o_m0_ack and o_m0_rdt=0x12345678 2 cycles after cyc; o_grant=01 during ACTIVE.
- m0 and m1 both assert cyc on the same edge after reset -> m0 served first. m1 receives o_s_cyc after m0's IDLE gap; m1 ack 5 cycles after the request.
- Both masters request continuously for 8 transactions -> grant sequence 01,10,01,10,...; no master ever sees two consecutive grants.
- m1 writes sel=4'b0010, dat=0xAABBCCDD to addr 0x10 over a word of 0; m0 then reads it -> rdt=0x0000CC00.
- Slave model never acks, TIMEOUT=16 -> o_m0_ack=1, o_m0_rdt=0, o_timeout pulse exactly 16 cycles after ACTIVE entry, then IDLE.
- Reset pulsed low during ACTIVE with m1 granted -> o_s_cyc=0 and o_grant=00 immediately, no m1 ack; after release, simultaneous requests grant m0 first.
